rxll_ll: RTL and testbench

- Receive-side LocalLink-to-FIFO writer. It is the counterpart of the transmit LocalLink reader.
- Accepts 32-bit frames (FIS dwords) from the link layer on a trn_r* LocalLink interface.
- Tags each dword with frame markers and writes it into a 36-bit receive FIFO.
- Applies backpressure from FIFO occupancy, enforces frame framing and maximum length, and reports per-frame completion, length and error to the transport layer.

---
 rtl/rxll_pkg.sv | 30 +++
 rtl/rxll_stats.sv | 37 +++
 rtl/rxll_ll.sv | 157 +++++++++++++++
 tb/tb_rxll_ll.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rxll_pkg.sv
// Shared definitions for the receive LocalLink-to-FIFO writer (rxll_ll):
// FSM state encoding, FIFO word layout and frame-length default.
package rxll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  localparam int SOF = 35;
  localparam int EOF = 34;
  localparam int ERR = 33;

  localparam int C_MAX_WORDS_DEF = 2049;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [35:0] fifo_word(input logic sof, input logic eof,
                                            input logic err, input logic [31:0] data);
    logic [35:0] w;
    w          = '0;
    w[SOF]     = sof;
    w[EOF]     = eof;
    w[ERR]     = err;
    w[31:0]    = data;
    return w;
  endfunction

endpackage

// File: rtl/rxll_stats.sv
// Saturating good-frame and error counters for rxll_ll; built only when
// RXLL_STATS_EN is defined.
module rxll_stats
  import rxll_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_frame,
  input  logic        inc_error,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);

  logic [15:0] frames_q, frames_d;
  logic [15:0] errors_q, errors_d;

  always_comb begin
    frames_d = frames_q;
    errors_d = errors_q;
    if (inc_frame && (frames_q != STAT_MAX)) frames_d = frames_q + 16'd1;
    if (inc_error && (errors_q != STAT_MAX)) errors_d = errors_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  assign stat_frames = frames_q;
  assign stat_errors = errors_q;

endmodule

// File: rtl/rxll_ll.sv
// Receive LocalLink-to-FIFO writer: tags each accepted dword with sof/eof/err and writes
// it into a 36-bit FIFO. Statistics counters are built only when RXLL_STATS_EN is defined.
module rxll_ll
  import rxll_pkg::*;
#(
  parameter int C_FIFO_DEPTH = 1024,
  parameter int C_HIGH_WATER = 1008,
  parameter int C_MAX_WORDS  = C_MAX_WORDS_DEF
) (
  input  logic        phyclk,
  input  logic        phyreset,
  input  logic [31:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  output logic        trn_rdst_rdy_n,
  output logic        wr_clk,
  output logic        wr_en,
  output logic [35:0] wr_di,
  input  logic [9:0]  wr_count,
  input  logic        wr_full,
  output logic        frame_done,
  output logic        frame_err,
  output logic [11:0] frame_len,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);

  // A threshold above DEPTH-4 would leave no room for the in-flight beats.
  localparam int          HW_EFF  = (C_HIGH_WATER > C_FIFO_DEPTH - 4) ? (C_FIFO_DEPTH - 4)
                                                                      : C_HIGH_WATER;
  localparam logic [10:0] HW_TH   = 11'(HW_EFF);
  localparam logic [11:0] MAX_LEN = 12'(C_MAX_WORDS);

  rx_state_e   state_q, state_d;
  logic [11:0] len_q, len_d, len_inc;
  logic        rdy_n_q, rdy_n_d;
  logic        wr_en_q, wr_en_d;
  logic [35:0] wr_di_q, wr_di_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [11:0] frame_len_q, frame_len_d;
  logic        beat, sof, eof, dsc, closing, bad;

  // Handshake: a beat transfers on a rising edge where trn_rsrc_rdy_n and trn_rdst_rdy_n are
  // both low; trn_rdst_rdy_n is a function of FIFO occupancy only, never of the source.
  assign beat = ~trn_rsrc_rdy_n & ~rdy_n_q;
  assign sof  = ~trn_rsof_n;
  assign eof  = ~trn_reof_n;
  assign dsc  = ~trn_rsrc_dsc_n;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    len_inc      = len_q + 12'd1;
    rdy_n_d      = ({1'b0, wr_count} >= HW_TH) | wr_full;
    wr_en_d      = 1'b0;
    wr_di_d      = wr_di_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_len_d  = frame_len_q;
    closing      = 1'b0;
    bad          = 1'b0;
    if (beat) begin
      case (state_q)
        IDLE: begin
          if (!sof || wr_full) begin
            frame_err_d = 1'b1;
            state_d     = eof ? IDLE : DROP;
          end else begin
            wr_en_d = 1'b1;
            wr_di_d = fifo_word(1'b1, eof, 1'b0, trn_rd);
            if (eof) begin
              frame_done_d = 1'b1;
              frame_len_d  = 12'd1;
            end else begin
              len_d   = 12'd1;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          // Every frame-ending event writes the same closing word; only err differs.
          closing = dsc | sof | eof | (len_inc == MAX_LEN);
          bad     = dsc | sof | (~eof & (len_inc == MAX_LEN));
          if (wr_full) begin
            frame_err_d = 1'b1;
            len_d       = '0;
            state_d     = eof ? IDLE : DROP;
          end else begin
            wr_en_d = 1'b1;
            wr_di_d = fifo_word(1'b0, closing, bad, trn_rd);
            if (closing) begin
              frame_done_d = 1'b1;
              frame_err_d  = bad;
              frame_len_d  = len_inc;
              len_d        = '0;
              state_d      = eof ? IDLE : DROP;
            end else begin
              len_d = len_inc;
            end
          end
        end
        DROP: begin
          if (eof) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge phyclk) begin
    if (phyreset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rdy_n_q      <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_di_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rdy_n_q      <= rdy_n_d;
      wr_en_q      <= wr_en_d;
      wr_di_q      <= wr_di_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign trn_rdst_rdy_n = rdy_n_q;
  assign wr_clk         = phyclk;
  assign wr_en          = wr_en_q;
  assign wr_di          = wr_di_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign frame_len      = frame_len_q;

`ifdef RXLL_STATS_EN
  rxll_stats u_stats (
    .clk         (phyclk),
    .rst         (phyreset),
    .inc_frame   (frame_done_q & ~frame_err_q),
    .inc_error   (frame_err_q),
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
  );
`else
  assign stat_frames = '0;
  assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_rxll_ll.sv
// Self-checking bench for rxll_ll: randomized LocalLink beats, a frame-level reference model
// filling expected queues, and a monitor that checks FIFO writes and frame events.
`timescale 1ns/1ps
module tb_rxll_ll;

  localparam int MAXW = 2049;

  logic        phyclk = 1'b0;
  logic        phyreset = 1'b1;
  logic [31:0] trn_rd = '0;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rsrc_dsc_n = 1'b1;
  logic        trn_rdst_rdy_n;
  logic        wr_clk;
  logic        wr_en;
  logic [35:0] wr_di;
  logic [9:0]  wr_count = '0;
  logic        wr_full = 1'b0;
  logic        frame_done;
  logic        frame_err;
  logic [11:0] frame_len;
  logic [15:0] stat_frames;
  logic [15:0] stat_errors;

  rxll_ll dut (
    .phyclk         (phyclk),
    .phyreset       (phyreset),
    .trn_rd         (trn_rd),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .wr_clk         (wr_clk),
    .wr_en          (wr_en),
    .wr_di          (wr_di),
    .wr_count       (wr_count),
    .wr_full        (wr_full),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frame_len      (frame_len),
    .stat_frames    (stat_frames),
    .stat_errors    (stat_errors)
  );

  // ---------------- clock / reset ----------------
  always #5 phyclk = ~phyclk;

  int cyc = 0;
  always @(posedge phyclk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [67:0] exp_q[$];     // {cycle, fifo word}
  logic [45:0] exp_ev_q[$];  // {cycle, done, err, len}

  bit m_in_frame = 1'b0;
  bit m_drop     = 1'b0;
  int m_len      = 0;
  int exp_good   = 0;
  int exp_errs   = 0;
  bit gap_en     = 1'b1;
  bit bp_en      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [35:0] word(input logic s, input logic e, input logic r,
                                       input logic [31:0] d);
    logic [35:0] w;
    w = {s, e, r, 1'b0, d};
    return w;
  endfunction

  task automatic push_wr(input logic [35:0] w);
    exp_q.push_back({32'(cyc + 1), w});
  endtask

  task automatic push_ev(input logic done, input logic err, input int len);
    exp_ev_q.push_back({32'(cyc + 1), done, err, 12'(len)});
    if (done && !err) exp_good++;
    if (err) exp_errs++;
  endtask

  // Reference model: applies the framing rules to one accepted beat.
  task automatic model_beat(input logic [31:0] d, input logic s, input logic e,
                            input logic ds, input logic f);
    bit abort, toolong;
    if (m_drop) begin
      if (e) m_drop = 1'b0;
      return;
    end
    if (!m_in_frame) begin
      if (!s || f) begin
        push_ev(1'b0, 1'b1, 0);
        m_drop = !e;
        return;
      end
      push_wr(word(1'b1, e, 1'b0, d));
      if (e) push_ev(1'b1, 1'b0, 1);
      else begin
        m_in_frame = 1'b1;
        m_len      = 1;
      end
      return;
    end
    m_len++;
    if (f) begin
      push_ev(1'b0, 1'b1, 0);
      m_in_frame = 1'b0;
      m_drop     = !e;
      return;
    end
    abort   = ds || s;
    toolong = (m_len == MAXW) && !e;
    if (abort || toolong || e) begin
      push_wr(word(1'b0, 1'b1, abort || toolong, d));
      push_ev(1'b1, abort || toolong, m_len);
      m_in_frame = 1'b0;
      m_drop     = !e;
    end else begin
      push_wr(word(1'b0, 1'b0, 1'b0, d));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge phyclk) begin
    logic [67:0] w;
    logic [45:0] ev;
    if (!phyreset) begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) fail_now("wr_unexpected", 64'(wr_di));
        else begin
          w = exp_q.pop_front();
          check("wr_word", 64'(wr_di), 64'(w[35:0]));
          check("wr_cycle", 64'(cyc), 64'(w[67:36]));
        end
      end
      if (frame_done === 1'b1 || frame_err === 1'b1) begin
        if (exp_ev_q.size() == 0) fail_now("ev_unexpected", 64'({frame_done, frame_err}));
        else begin
          ev = exp_ev_q.pop_front();
          check("ev_flags", 64'({frame_done, frame_err}), 64'(ev[13:12]));
          check("ev_cycle", 64'(cyc), 64'(ev[45:14]));
          if (ev[13]) check("frame_len", 64'(frame_len), 64'(ev[11:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    @(negedge phyclk);
    trn_rsrc_rdy_n = 1'b1;
    wr_full        = 1'b0;
    repeat (n - 1) @(negedge phyclk);
  endtask

  task automatic bp_burst();
    @(negedge phyclk);
    trn_rsrc_rdy_n = 1'b1;
    wr_count       = 10'($urandom_range(1008, 1023));
    repeat ($urandom_range(2, 5)) @(negedge phyclk);
    wr_count = 10'($urandom_range(0, 1007));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic ds, input logic f);
    int waits = 0;
    @(negedge phyclk);
    wr_full        = 1'b0;
    trn_rd         = d;
    trn_rsof_n     = !s;
    trn_reof_n     = !e;
    trn_rsrc_dsc_n = !ds;
    trn_rsrc_rdy_n = 1'b0;
    while (trn_rdst_rdy_n === 1'b1 && waits < 200) begin
      @(negedge phyclk);
      waits++;
    end
    check("rdy_within_bound", 64'(trn_rdst_rdy_n), 64'd0);
    if (trn_rdst_rdy_n !== 1'b0) begin
      trn_rsrc_rdy_n = 1'b1;
      return;
    end
    wr_full = f;
    model_beat(d, s, e, ds, f);
  endtask

  // bad_kind: 0 none, 1 discontinue, 2 restart sof, 3 FIFO full on that beat
  task automatic send_frame(input int n, input int bad_at, input int bad_kind);
    for (int i = 0; i < n; i++) begin
      logic s, e, ds, f;
      s  = (i == 0);
      e  = (i == n - 1);
      ds = 1'b0;
      f  = 1'b0;
      if (i == bad_at && i > 0) begin
        if (bad_kind == 1) ds = 1'b1;
        if (bad_kind == 2) s = 1'b1;
        if (bad_kind == 3) f = 1'b1;
      end
      if (bp_en && $urandom_range(0, 7) == 0) bp_burst();
      if (gap_en && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_beat($urandom, s, e, ds, f);
    end
  endtask

  task automatic do_reset();
    @(negedge phyclk);
    phyreset       = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    wr_full        = 1'b0;
    wr_count       = '0;
    repeat (2) @(negedge phyclk);
    check("rst_rdst_rdy_n", 64'(trn_rdst_rdy_n), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_di", 64'(wr_di), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frame_len", 64'(frame_len), 64'd0);
    check("rst_stat_frames", 64'(stat_frames), 64'd0);
    check("rst_stat_errors", 64'(stat_errors), 64'd0);
    check("wr_clk_follows", 64'(wr_clk), 64'(phyclk));
    phyreset   = 1'b0;
    m_in_frame = 1'b0;
    m_drop     = 1'b0;
    m_len      = 0;
    exp_good   = 0;
    exp_errs   = 0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wr_q_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_ev_q_empty"}, 64'(exp_ev_q.size()), 64'd0);
  endtask

  task automatic check_stats();
    int sf, se;
`ifdef RXLL_STATS_EN
    sf = exp_good;
    se = exp_errs;
`else
    sf = 0;
    se = 0;
`endif
    check("stat_frames", 64'(stat_frames), 64'(sf));
    check("stat_errors", 64'(stat_errors), 64'(se));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    do_reset();

    // four-word frame
    send_beat(32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat(32'h1000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h1000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // single-beat frame, then frame_len must hold
    send_beat(32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("frame_len_hold", 64'(frame_len), 64'd1);

    // backpressure mid-frame
    send_beat($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge phyclk);
    trn_rsrc_rdy_n = 1'b1;
    wr_count       = 10'd1008;
    @(negedge phyclk);
    check("bp_assert", 64'(trn_rdst_rdy_n), 64'd1);
    held           = $urandom;
    trn_rd         = held;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b0;
    repeat (4) begin
      @(negedge phyclk);
      check("bp_hold", 64'(trn_rdst_rdy_n), 64'd1);
    end
    wr_count = 10'd1000;
    send_beat(held, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // over-length frame: 2050 beats, beat 2049 closes with err, beat 2050 dropped
    gap_en = 1'b0;
    send_beat($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 2050; i++) send_beat($urandom, 1'b0, (i == 2050), 1'b0, 1'b0);
    gap_en = 1'b1;
    send_frame(3, -1, 0);
    idle(3);
    check("frame_len_after_long", 64'(frame_len), 64'd3);

    // stray beats, then discontinue / restart / overrun cases
    send_beat($urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    send_beat($urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(6, 2, 1);
    send_frame(4, 1, 2);
    send_frame(4, 3, 1);
    send_frame(5, 2, 3);
    send_frame(2, -1, 0);

    // randomized traffic with backpressure bursts
    bp_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind, n;
      kind = $urandom_range(0, 9);
      n    = $urandom_range(2, 8);
      if (kind == 0) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (kind <= 3) send_frame(n, $urandom_range(1, n - 1), kind);
      else send_frame($urandom_range(1, 8), -1, 0);
    end
    bp_en = 1'b0;
    send_frame(2, -1, 0);
    idle(4);
    check_drained("random");
    check_stats();

    // reset mid-frame, then a clean frame
    send_beat($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_drained("pre_reset");
    do_reset();
    send_frame(3, -1, 0);
    idle(4);
    check("frame_len_post_reset", 64'(frame_len), 64'd3);
    check_drained("final");
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
